lcd_bus_decoder: RTL and testbench

Receiving end of the HD44780-style character-LCD bus that the system drives (LCD_DATA/LCD_RS/LCD_RW/LCD_EN/LCD_ON). It samples the bus in the SYS_clk domain and decodes each write transaction into instruction or data effects. It maintains a 2x16 shadow of display RAM plus the address counter and control flags. The block serves as an on-chip loopback monitor and a synthesizable bench model, and it exposes a registered read port for the screen contents.

---
 rtl/lcd_bus_if.sv | 10 +
 rtl/lcd_bus_decoder.sv | 124 ++++++++++++
 tb/tb_lcd_bus_decoder.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_if.sv
// lcd_bus_if: HD44780-style character-LCD bus as driven by the system
interface lcd_bus_if;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_ON;
    modport master (output LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON);
    modport slave  (input  LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON);
endinterface

// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: samples the LCD bus, decodes writes and keeps a 2x16 shadow of display RAM
module lcd_bus_decoder #(
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic       SYS_clk,
    input  logic       SYS_rst,
    lcd_bus_if.slave   bus,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       busy,
    output logic       cmd_strobe,
    output logic [7:0] last_byte,
    output logic       overrun
);
    typedef enum logic {IDLE, CLEAR} state_t;
    typedef struct packed {
        logic [7:0] data;
        logic       rs;
        logic       rw;
        logic       en;
        logic       on;
    } samp_t;

    samp_t      sa, sb;
    state_t     state, state_nx;
    logic [4:0] clr_idx;
    logic [7:0] shadow [32];
    logic [7:0] d;
    logic       valid, accept;
    logic [6:0] ac_nx;
    logic       disp_nx, cursor_nx, blink_nx, inc_nx, ovr_nx;
    logic       wr_en;
    logic [4:0] wr_idx;
    logic [7:0] wr_data;

    // Steps the DDRAM address, hopping between the two 16-column lines
    function automatic logic [6:0] step(input logic [6:0] a, input logic up);
        return up ? ((a[3:0] == 4'hF) ? {~a[6], 6'h00} : a + 7'd1)
                  : ((a[3:0] == 4'h0) ? {~a[6], 2'b00, 4'hF} : a - 7'd1);
    endfunction

    assign busy = (state == CLEAR);

    always_comb begin
        d         = sb.data;
        valid     = sb.en & ~sa.en & sb.on & ~sb.rw;
        accept    = valid & ~busy;
        state_nx  = (busy && clr_idx == 5'd31) ? IDLE : state;
        ac_nx     = ac;
        disp_nx   = disp_on;
        cursor_nx = cursor_on;
        blink_nx  = blink_on;
        inc_nx    = entry_inc;
        ovr_nx    = overrun | (valid & busy);
        wr_en     = busy;
        wr_idx    = clr_idx;
        wr_data   = CLEAR_CHAR;
        if (accept) begin
            if (sb.rs) begin
                wr_en   = 1'b1;
                wr_idx  = {ac[6], ac[3:0]};
                wr_data = d;
                ac_nx   = step(ac, entry_inc);
            end else if (d[7]) begin
                if (d[5:4] == 2'b00) ac_nx = d[6:0];
                else ovr_nx = 1'b1;
            end else if (d[6:5] == 2'b00) begin
                if (d[4]) begin
                    if (!d[3]) ac_nx = step(ac, d[2]);
                end else if (d[3]) {disp_nx, cursor_nx, blink_nx} = d[2:0];
                else if (d[2]) inc_nx = d[1];
                else if (d[1]) ac_nx = 7'h00;
                else if (d[0]) begin
                    state_nx = CLEAR;
                    ac_nx    = 7'h00;
                    inc_nx   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge SYS_clk or posedge SYS_rst)
        if (SYS_rst) begin
            sa         <= '0;
            sb         <= '0;
            state      <= IDLE;
            clr_idx    <= 5'd0;
            ac         <= 7'h00;
            disp_on    <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            entry_inc  <= 1'b1;
            overrun    <= 1'b0;
            cmd_strobe <= 1'b0;
            last_byte  <= 8'h00;
        end else begin
            sa         <= {bus.LCD_DATA, bus.LCD_RS, bus.LCD_RW, bus.LCD_EN, bus.LCD_ON};
            sb         <= sa;
            state      <= state_nx;
            clr_idx    <= busy ? clr_idx + 5'd1 : 5'd0;
            ac         <= ac_nx;
            disp_on    <= disp_nx;
            cursor_on  <= cursor_nx;
            blink_on   <= blink_nx;
            entry_inc  <= inc_nx;
            overrun    <= ovr_nx;
            cmd_strobe <= accept;
            last_byte  <= accept ? d : last_byte;
        end

    always_ff @(posedge SYS_clk or posedge SYS_rst)
        if (SYS_rst) begin
            for (int i = 0; i < 32; i++) shadow[i] <= CLEAR_CHAR;
            rd_char <= CLEAR_CHAR;
        end else begin
            if (wr_en) shadow[wr_idx] <= wr_data;
            rd_char <= shadow[rd_addr];
        end
endmodule

// File: tb/tb_lcd_bus_decoder.sv
// tb_lcd_bus_decoder: directed and randomized bus transactions against a behavioural screen model
module tb_lcd_bus_decoder;
    logic       SYS_clk = 1'b0;
    logic       SYS_rst;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on, entry_inc, busy, cmd_strobe, overrun;
    logic [7:0] last_byte;
    int checks = 0;
    int failures = 0;
    int strobes = 0;

    lcd_bus_if bus();

    lcd_bus_decoder dut (
        .SYS_clk(SYS_clk), .SYS_rst(SYS_rst), .bus(bus), .rd_addr(rd_addr), .rd_char(rd_char),
        .ac(ac), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .entry_inc(entry_inc), .busy(busy), .cmd_strobe(cmd_strobe), .last_byte(last_byte),
        .overrun(overrun)
    );

    always #5 SYS_clk = ~SYS_clk;
    always @(negedge SYS_clk) if (cmd_strobe === 1'b1) strobes++;

    // Screen model: cursor as a linear position 0..31 over both lines
    logic [7:0] m_mem [32];
    int         m_pos;
    bit         m_inc, m_disp, m_cur, m_blink, m_ovr;
    logic [7:0] m_last;

    function automatic logic [6:0] m_ac();
        return 7'(m_pos < 16 ? m_pos : m_pos + 48);
    endfunction

    function automatic logic [21:0] dut_vec();
        return {ac, entry_inc, disp_on, cursor_on, blink_on, busy, overrun, cmd_strobe, last_byte};
    endfunction

    function automatic logic [21:0] model_vec();
        return {m_ac(), m_inc, m_disp, m_cur, m_blink, 1'b0, m_ovr, 1'b0, m_last};
    endfunction

    task automatic model_reset();
        foreach (m_mem[i]) m_mem[i] = 8'h20;
        m_pos = 0; m_inc = 1; m_disp = 0; m_cur = 0; m_blink = 0; m_ovr = 0; m_last = 8'h00;
    endtask

    task automatic model_apply(bit rs, bit rw, bit on, logic [7:0] d, output bit acc);
        int a;
        acc = on && !rw;
        if (!acc) return;
        m_last = d;
        a = int'(d) % 128;
        if (rs) begin
            m_mem[m_pos] = d;
            m_pos = m_inc ? (m_pos + 1) % 32 : (m_pos + 31) % 32;
        end else if (d == 8'h01) begin
            foreach (m_mem[i]) m_mem[i] = 8'h20;
            m_pos = 0; m_inc = 1;
        end else if (d >= 2 && d < 4) m_pos = 0;
        else if (d >= 4 && d < 8) m_inc = d[1];
        else if (d >= 8 && d < 16) {m_disp, m_cur, m_blink} = d[2:0];
        else if (d >= 16 && d < 32) begin
            if (!d[3]) m_pos = d[2] ? (m_pos + 1) % 32 : (m_pos + 31) % 32;
        end else if (d >= 128) begin
            if ((a / 16) % 4 == 0) m_pos = (a >= 64 ? 16 : 0) + a % 16;
            else m_ovr = 1;
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge SYS_clk);
    endtask

    task automatic txn(bit rs, bit rw, bit on, logic [7:0] d, int hold, int gap);
        @(negedge SYS_clk);
        bus.LCD_DATA = d; bus.LCD_RS = rs; bus.LCD_RW = rw; bus.LCD_ON = on; bus.LCD_EN = 1'b1;
        idle(hold);
        bus.LCD_EN = 1'b0;
        idle(gap);
        bus.LCD_ON = 1'b1;
    endtask

    task automatic send(bit rs, bit rw, bit on, logic [7:0] d, output bit acc);
        txn(rs, rw, on, d, $urandom_range(2, 4), $urandom_range(3, 5));
        model_apply(rs, rw, on, d, acc);
        if (acc && !rs && d == 8'h01) idle(34);
    endtask

    task automatic rd(int a, output logic [7:0] v);
        @(negedge SYS_clk) rd_addr = 5'(a);
        @(negedge SYS_clk) v = rd_char;
    endtask

    task automatic do_reset();
        bus.LCD_EN = 1'b0; bus.LCD_ON = 1'b1; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_DATA = 8'h00;
        @(negedge SYS_clk) SYS_rst = 1'b1;
        idle(2);
        SYS_rst = 1'b0;
        model_reset();
        idle(1);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        do_reset();
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), model_vec());
        end
        checks++;
        if (ac !== 7'h00 || entry_inc !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_ac_inc_busy got=%h/%b/%b exp=00/1/0", ac, entry_inc, busy);
        end
        for (int i = 0; i < 32; i++) begin
            rd(i, v);
            checks++;
            if (v !== 8'h20) begin failures++; $display("FAIL reset_cell[%0d] got=%h exp=20", i, v); end
        end
    endtask

    task automatic test_basic();
        logic [7:0] v0, v1;
        bit a;
        int s0 = strobes;
        send(0, 0, 1, 8'h0C, a);
        send(1, 0, 1, 8'h48, a);
        send(1, 0, 1, 8'h49, a);
        rd(0, v0);
        rd(1, v1);
        checks++;
        if (strobes - s0 !== 3) begin failures++; $display("FAIL basic_strobes got=%0d exp=3", strobes - s0); end
        checks++;
        if ({disp_on, cursor_on, ac} !== {2'b10, 7'h02}) begin
            failures++; $display("FAIL basic_flags_ac got=%b%b/%h exp=10/02", disp_on, cursor_on, ac);
        end
        checks++;
        if ({v0, v1} !== 16'h4849) begin failures++; $display("FAIL basic_cells got=%h%h exp=4849", v0, v1); end
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++; $display("FAIL basic_state got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_addr();
        logic [7:0] v0, v1;
        bit a;
        send(0, 0, 1, 8'h8F, a);
        send(1, 0, 1, 8'h41, a);
        send(1, 0, 1, 8'h42, a);
        rd(15, v0);
        rd(16, v1);
        checks++;
        if ({ac, v0, v1} !== {7'h41, 16'h4142}) begin
            failures++; $display("FAIL addr_wrap_fwd got=%h/%h%h exp=41/4142", ac, v0, v1);
        end
        send(0, 0, 1, 8'h04, a);
        send(0, 0, 1, 8'h80, a);
        send(1, 0, 1, 8'h43, a);
        rd(0, v0);
        checks++;
        if ({ac, entry_inc, v0} !== {7'h4F, 1'b0, 8'h43}) begin
            failures++; $display("FAIL addr_wrap_back got=%h/%b/%h exp=4f/0/43", ac, entry_inc, v0);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++; $display("FAIL addr_state got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_clear();
        logic [7:0] v;
        bit a;
        int n = 0;
        int s0 = strobes;
        fork
            begin
                txn(0, 0, 1, 8'h01, 2, 3);
                idle(6);
                txn(1, 0, 1, 8'h77, 2, 3);
            end
            begin
                int t = 0;
                while (busy !== 1'b1 && t < 50) begin @(negedge SYS_clk); t++; end
                while (busy === 1'b1 && n < 100) begin n++; @(negedge SYS_clk); end
            end
        join
        model_apply(0, 0, 1, 8'h01, a);
        m_ovr = 1;
        idle(2);
        checks++;
        if (n !== 32) begin failures++; $display("FAIL clear_busy_cycles got=%0d exp=32", n); end
        checks++;
        if (strobes - s0 !== 1) begin failures++; $display("FAIL clear_strobes got=%0d exp=1", strobes - s0); end
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++; $display("FAIL clear_state got=%h exp=%h", dut_vec(), model_vec());
        end
        for (int i = 0; i < 32; i++) begin
            rd(i, v);
            checks++;
            if (v !== 8'h20) begin failures++; $display("FAIL clear_cell[%0d] got=%h exp=20", i, v); end
        end
    endtask

    // late=0: write detected in the cycle of the last fill write; late=1: one cycle after
    task automatic test_clear_edge(bit late);
        logic [7:0] v;
        bit a;
        int t = 0;
        int s0;
        do_reset();
        s0 = strobes;
        @(negedge SYS_clk);
        bus.LCD_DATA = 8'h01; bus.LCD_RS = 1'b0; bus.LCD_EN = 1'b1;
        idle(2);
        bus.LCD_EN = 1'b0;
        while (busy !== 1'b1 && t < 10) begin @(negedge SYS_clk); t++; end
        idle(28 + int'(late));
        bus.LCD_DATA = 8'h66; bus.LCD_RS = 1'b1; bus.LCD_EN = 1'b1;
        idle(2);
        bus.LCD_EN = 1'b0;
        idle(6);
        model_apply(0, 0, 1, 8'h01, a);
        if (late) model_apply(1, 0, 1, 8'h66, a);
        else m_ovr = 1;
        rd(0, v);
        checks++;
        if (strobes - s0 !== 1 + int'(late)) begin
            failures++; $display("FAIL clear_edge%0d_strobes got=%0d exp=%0d", late, strobes - s0, 1 + int'(late));
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++; $display("FAIL clear_edge%0d_state got=%h exp=%h", late, dut_vec(), model_vec());
        end
        checks++;
        if (v !== m_mem[0]) begin failures++; $display("FAIL clear_edge%0d_cell0 got=%h exp=%h", late, v, m_mem[0]); end
    endtask

    task automatic test_bad_addr();
        logic [7:0] v;
        bit a;
        int s0;
        do_reset();
        send(0, 0, 1, 8'h0F, a);
        send(1, 0, 1, 8'h31, a);
        s0 = strobes;
        send(0, 0, 1, 8'h90, a);
        checks++;
        if ({ac, overrun, last_byte} !== {7'h01, 1'b1, 8'h90} || strobes - s0 !== 1) begin
            failures++;
            $display("FAIL bad_addr got=%h/%b/%h/%0d exp=01/1/90/1", ac, overrun, last_byte, strobes - s0);
        end
        send(0, 0, 1, 8'hE5, a);
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++; $display("FAIL bad_addr_e5 got=%h exp=%h", dut_vec(), model_vec());
        end
        s0 = strobes;
        send(1, 1, 1, 8'h48, a);
        send(1, 0, 0, 8'h55, a);
        send(0, 0, 0, 8'h01, a);
        rd(1, v);
        checks++;
        if (strobes - s0 !== 0) begin failures++; $display("FAIL ignored_strobes got=%0d exp=0", strobes - s0); end
        checks++;
        if (dut_vec() !== model_vec() || v !== 8'h20) begin
            failures++; $display("FAIL ignored_state got=%h/%h exp=%h/20", dut_vec(), v, model_vec());
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [7:0] v;
        bit a;
        int t = 0;
        int s0;
        send(1, 0, 1, 8'h3C, a);
        txn(0, 0, 1, 8'h01, 2, 0);
        while (busy !== 1'b1 && t < 10) begin @(negedge SYS_clk); t++; end
        idle(4);
        SYS_rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        idle(2);
        SYS_rst = 1'b0;
        model_reset();
        idle(1);
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++; $display("FAIL rst_mid_state got=%h exp=%h", dut_vec(), model_vec());
        end
        for (int i = 0; i < 32; i++) begin
            rd(i, v);
            checks++;
            if (v !== 8'h20) begin failures++; $display("FAIL rst_mid_cell[%0d] got=%h exp=20", i, v); end
        end
        s0 = strobes;
        send(1, 0, 1, 8'h5A, a);
        rd(0, v);
        checks++;
        if (v !== 8'h5A || ac !== 7'h01 || strobes - s0 !== 1) begin
            failures++; $display("FAIL rst_mid_write got=%h/%h/%0d exp=5a/01/1", v, ac, strobes - s0);
        end
    endtask

    task automatic test_random();
        logic [7:0] v, d;
        bit rs, rw, on, a;
        int r, s0;
        for (int k = 0; k < 80; k++) begin
            rs = 0; rw = 0; on = 1;
            d = 8'($urandom);
            r = $urandom_range(0, 99);
            if (r < 40) rs = 1;
            else if (r < 50) d = 8'h10 | 8'($urandom_range(0, 15));
            else if (r < 58) d = 8'($urandom_range(4, 7));
            else if (r < 64) d = 8'($urandom_range(8, 15));
            else if (r < 68) d = 8'($urandom_range(2, 3));
            else if (r < 78) d = 8'h80 | 8'($urandom_range(0, 1) * 64) | 8'($urandom_range(0, 15));
            else if (r < 82) d = 8'h80 | 8'($urandom_range(0, 127));
            else if (r < 86) d = 8'($urandom_range(0, 1) * $urandom_range(32, 127));
            else if (r < 90) begin rw = 1; rs = 1'($urandom); end
            else if (r < 95) begin on = 0; rs = 1'($urandom); end
            else d = 8'h01;
            s0 = strobes;
            send(rs, rw, on, d, a);
            checks++;
            if (strobes - s0 !== int'(a)) begin
                failures++; $display("FAIL rnd[%0d]_strobe got=%0d exp=%0d", k, strobes - s0, a);
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++; $display("FAIL rnd[%0d]_state rs=%b d=%h got=%h exp=%h", k, rs, d, dut_vec(), model_vec());
            end
        end
        for (int i = 0; i < 32; i++) begin
            rd(i, v);
            checks++;
            if (v !== m_mem[i]) begin failures++; $display("FAIL rnd_cell[%0d] got=%h exp=%h", i, v, m_mem[i]); end
        end
    endtask

    initial begin
        SYS_rst = 1'b0;
        rd_addr = 5'd0;
        bus.LCD_DATA = 8'h00; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_EN = 1'b0; bus.LCD_ON = 1'b1;
        test_reset();
        test_basic();
        test_addr();
        test_clear();
        test_clear_edge(1'b0);
        test_clear_edge(1'b1);
        test_bad_addr();
        test_reset_mid_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
